// File: rtl/compute_group_pkg.sv
// rtl/compute_group_pkg.sv - shared types for the global-memory bridge
package compute_group_pkg;

  localparam int GM_ADDR_W = 17;
  localparam int GM_DATA_W = 32;

  typedef struct packed {
    logic [GM_ADDR_W-1:0] addr;
    logic [GM_DATA_W-1:0] data;
  } gm_wr_t;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD_REQ,
    RD_WAIT
  } bridge_state_t;

endpackage

// File: rtl/gm_wbuf_fifo.sv
// rtl/gm_wbuf_fifo.sv - posted-write buffer, synchronous FIFO of gm_wr_t
module gm_wbuf_fifo
  import compute_group_pkg::*;
#(
  parameter int WBUF_DEPTH = 4,
  localparam int CW = $clog2(WBUF_DEPTH + 1),
  localparam int PW = $clog2(WBUF_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  gm_wr_t        wdata,
  input  logic          pop,
  output gm_wr_t        head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  gm_wr_t        mem [WBUF_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(WBUF_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Payload storage carries no reset; count/pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (!push_ok && pop_ok) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/gm_bridge.sv
// rtl/gm_bridge.sv - local_memory to global-memory arbiter bridge
// Posted writes drain in order; a single read is issued only after the buffer empties.
module gm_bridge
  import compute_group_pkg::*;
#(
  parameter int WBUF_DEPTH   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clock_50,
  input  logic                 reset,
  input  logic [GM_ADDR_W-1:0] lm_gm_addr,
  input  logic [GM_DATA_W-1:0] lm_gm_data,
  input  logic                 lm_gm_we,
  input  logic                 lm_gm_re,
  output logic [GM_DATA_W-1:0] gm_lm_data,
  output logic                 gm_lm_valid,
  output logic                 gm_lm_stall,
  output logic                 br_gm_req,
  input  logic                 gm_br_gnt,
  output logic [GM_ADDR_W-1:0] br_gm_addr,
  output logic [GM_DATA_W-1:0] br_gm_data,
  output logic                 br_gm_we,
  input  logic [GM_DATA_W-1:0] gm_br_data
);

  localparam int CW = $clog2(WBUF_DEPTH + 1);
  localparam int LW = $clog2(READ_LATENCY + 1);

  bridge_state_t        state;
  bridge_state_t        state_next;
  gm_wr_t               head;
  gm_wr_t               wr_in;
  logic [CW-1:0]        count;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 rd_accept;
  logic                 rd_pending;
  logic [GM_ADDR_W-1:0] rd_addr;
  logic [LW-1:0]        lat_cnt;

  assign gm_lm_stall = full | rd_pending;
  assign push        = lm_gm_we & ~gm_lm_stall;
  assign rd_accept   = lm_gm_re & ~gm_lm_stall;
  assign pop         = (state == WR) & gm_br_gnt;
  assign wr_in       = '{addr: lm_gm_addr, data: lm_gm_data};

  gm_wbuf_fifo #(
    .WBUF_DEPTH(WBUF_DEPTH)
  ) u_wbuf (
    .clk  (clock_50),
    .reset(reset),
    .push (push),
    .wdata(wr_in),
    .pop  (pop),
    .head (head),
    .count(count),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_next = WR;
        end else if (rd_pending) begin
          state_next = RD_REQ;
        end
      end
      WR: begin
        // A same-cycle push keeps the buffer nonempty even when the last entry pops.
        if (gm_br_gnt && (count == CW'(1)) && !push) begin
          state_next = rd_pending ? RD_REQ : IDLE;
        end
      end
      RD_REQ: begin
        if (gm_br_gnt) begin
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_cnt == LW'(1)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    br_gm_req  = 1'b0;
    br_gm_we   = 1'b0;
    br_gm_addr = '0;
    br_gm_data = '0;
    case (state)
      WR: begin
        br_gm_req  = 1'b1;
        br_gm_we   = 1'b1;
        br_gm_addr = head.addr;
        br_gm_data = head.data;
      end
      RD_REQ: begin
        br_gm_req  = 1'b1;
        br_gm_addr = rd_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      rd_pending  <= 1'b0;
      rd_addr     <= '0;
      lat_cnt     <= '0;
      gm_lm_data  <= '0;
      gm_lm_valid <= 1'b0;
    end else begin
      gm_lm_valid <= 1'b0;
      if (rd_accept) begin
        rd_pending <= 1'b1;
        rd_addr    <= lm_gm_addr;
      end
      if (state == RD_REQ && gm_br_gnt) begin
        lat_cnt <= LW'(READ_LATENCY);
      end
      if (state == RD_WAIT) begin
        if (lat_cnt == LW'(1)) begin
          lat_cnt     <= '0;
          gm_lm_data  <= gm_br_data;
          gm_lm_valid <= 1'b1;
          rd_pending  <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt - 1'b1;
        end
      end
    end
  end

endmodule
